mem_wb_skid_stage: RTL and testbench

Parametrised MEM→WB pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a hazard-unit forwarding tap. It carries destination register index, store/load data, ALU result and the memory-read/write-back control bits. It replaces the always-enabled fixed-width stage register wherever the memory stage can stall, for example on a multi-cycle data memory or SRAM controller.

---
 rtl/mem_wb_pkg.sv | 19 +
 rtl/mem_wb_skid_stage_skid_buffer.sv | 91 +++++++++
 rtl/mem_wb_skid_stage.sv | 72 +++++++
 tb/tb_mem_wb_skid_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and sizing helpers for the MEM->WB skid stage.
package mem_wb_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF     = 32;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic int unsigned bundle_w(input int unsigned reg_addr_w,
                                           input int unsigned data_w);
    return reg_addr_w + 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/mem_wb_skid_stage_skid_buffer.sv
// Generic valid/ready buffer over a packed bundle: two entries with a
// registered ready (SKID=1) or one entry with a combinational ready (SKID=0).
module skid_buffer
  import mem_wb_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q;
  logic         valid;
  logic         in_fire;
  logic         out_fire;

  assign valid    = (state_q != EMPTY);
  // An entry offered during flush is dropped even when ready is high.
  assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire = valid & out_ready_i;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && SKID) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end
        end
        FULL: begin
          if (out_ready_i) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is held low during reset; SKID=1 takes it from a register only.
  always_comb begin
    out_valid_o = valid;
    out_data_o  = main_q;
    occupancy_o = state_q;
    in_ready_o  = ~rst_i & (SKID ? rdy_q : (out_ready_i | ~valid));
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with valid/ready handshake, skid buffer, flush
// and a hazard-unit forwarding tap on the head entry.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter bit          SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] destination_in,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     aluResult_in,
  input  logic                  memoryReadEnabled_in,
  input  logic                  writeBackEnabled_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] destination,
  output logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     aluResult,
  output logic                  memoryReadEnabled,
  output logic                  writeBackEnabled,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [1:0]            occupancy
);

  localparam int unsigned BW = bundle_w(REG_ADDR_W, DATA_W);

  logic [BW-1:0]         in_bundle;
  logic [BW-1:0]         head;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0]     head_data;
  logic [DATA_W-1:0]     head_alu;
  logic                  head_mre;
  logic                  head_wbe;

  assign in_bundle = {destination_in, data_in, aluResult_in,
                      memoryReadEnabled_in, writeBackEnabled_in};

  skid_buffer #(
    .W    (BW),
    .SKID (SKID)
  ) u_skid (
    .clk         (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_bundle),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head),
    .occupancy_o (occupancy)
  );

  assign {head_dest, head_data, head_alu, head_mre, head_wbe} = head;

  // Payload survives a flush, so control bits must be gated by valid.
  assign destination       = head_dest;
  assign data              = head_data;
  assign aluResult         = head_alu;
  assign memoryReadEnabled = out_valid & head_mre;
  assign writeBackEnabled  = out_valid & head_wbe;
  assign fwd_valid         = out_valid & head_wbe;
  assign fwd_dest          = head_dest;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage, SKID=1 and SKID=0 builds side by side.
module tb_mem_wb_skid_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic        a_flush, a_iv, a_ird, a_mre, a_wbe, a_ov, a_ord;
  logic [3:0]  a_dst, a_odst, a_fd;
  logic [31:0] a_dat, a_alu, a_odat, a_oalu;
  logic        a_omre, a_owbe, a_fv;
  logic [1:0]  a_occ;
  // SKID=0 instance signals
  logic        b_flush, b_iv, b_ird, b_mre, b_wbe, b_ov, b_ord;
  logic [3:0]  b_dst, b_odst, b_fd;
  logic [31:0] b_dat, b_alu, b_odat, b_oalu;
  logic        b_omre, b_owbe, b_fv;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;

  mem_wb_skid_stage #(.REG_ADDR_W(4), .DATA_W(32), .SKID(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ird),
    .destination_in(a_dst), .data_in(a_dat), .aluResult_in(a_alu),
    .memoryReadEnabled_in(a_mre), .writeBackEnabled_in(a_wbe),
    .out_valid(a_ov), .out_ready(a_ord), .destination(a_odst), .data(a_odat),
    .aluResult(a_oalu), .memoryReadEnabled(a_omre), .writeBackEnabled(a_owbe),
    .fwd_valid(a_fv), .fwd_dest(a_fd), .occupancy(a_occ)
  );

  mem_wb_skid_stage #(.REG_ADDR_W(4), .DATA_W(32), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ird),
    .destination_in(b_dst), .data_in(b_dat), .aluResult_in(b_alu),
    .memoryReadEnabled_in(b_mre), .writeBackEnabled_in(b_wbe),
    .out_valid(b_ov), .out_ready(b_ord), .destination(b_odst), .data(b_odat),
    .aluResult(b_oalu), .memoryReadEnabled(b_omre), .writeBackEnabled(b_owbe),
    .fwd_valid(b_fv), .fwd_dest(b_fd), .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_put(input logic v, input logic [3:0] d, input logic [31:0] alu,
                       input logic mre, input logic wbe);
    a_iv  = v;
    a_dst = d;
    a_alu = alu;
    a_dat = alu ^ 32'hFFFF_0000;
    a_mre = mre;
    a_wbe = wbe;
  endtask

  initial begin
    a_flush = 1'b0; a_ord = 1'b1; a_put(1'b1, 4'd9, 32'h55, 1'b1, 1'b1);
    b_flush = 1'b0; b_ord = 1'b1; b_iv = 1'b1; b_dst = 4'd9; b_alu = 32'h55;
    b_dat = 32'h66; b_mre = 1'b1; b_wbe = 1'b1;

    // Reset held two cycles with traffic offered
    step();
    step();
    chk("rst out_valid", a_ov, 0);
    chk("rst in_ready", a_ird, 0);
    chk("rst dest", a_odst, 0);
    chk("rst data", a_odat, 0);
    chk("rst alu", a_oalu, 0);
    chk("rst mre", a_omre, 0);
    chk("rst wbe", a_owbe, 0);
    chk("rst fwd_valid", a_fv, 0);
    chk("rst fwd_dest", a_fd, 0);
    chk("rst occ", a_occ, 0);
    chk("rst s0 in_ready", b_ird, 0);
    chk("rst s0 out_valid", b_ov, 0);
    rst = 1'b0;
    a_iv = 1'b0;
    b_iv = 1'b0;
    #1;
    chk("post-rst in_ready", a_ird, 1);
    chk("post-rst occ", a_occ, 0);
    chk("post-rst s0 in_ready", b_ird, 1);
    step();
    chk("idle out_valid", a_ov, 0);

    // Streaming, no bubbles
    for (int i = 1; i <= 8; i++) begin
      a_put(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 1'b1);
      step();
      chk("stream valid", a_ov, 1);
      chk("stream dest", a_odst, 64'(i));
      chk("stream alu", a_oalu, 64'(32'h100 + 32'(i)));
      chk("stream data", a_odat, 64'((32'h100 + 32'(i)) ^ 32'hFFFF_0000));
      chk("stream in_ready", a_ird, 1);
    end
    a_iv = 1'b0;
    step();
    chk("stream drain valid", a_ov, 0);
    chk("stream drain occ", a_occ, 0);

    // Backpressure: A=3, B=5 absorbed, C=6 held upstream
    a_ord = 1'b0;
    a_put(1'b1, 4'd3, 32'hA, 1'b0, 1'b1);
    step();
    chk("bp A occ", a_occ, 1);
    chk("bp A in_ready", a_ird, 1);
    chk("bp A head", a_odst, 3);
    a_put(1'b1, 4'd5, 32'hB, 1'b0, 1'b1);
    step();
    chk("bp B occ", a_occ, 2);
    chk("bp B in_ready", a_ird, 0);
    chk("bp B head", a_odst, 3);
    a_put(1'b1, 4'd6, 32'hC, 1'b0, 1'b1);
    step();
    chk("bp hold occ", a_occ, 2);
    chk("bp hold head", a_odst, 3);
    chk("bp hold alu", a_oalu, 32'hA);
    a_ord = 1'b1;
    step();
    chk("bp drain1 head", a_odst, 5);
    chk("bp drain1 alu", a_oalu, 32'hB);
    chk("bp drain1 occ", a_occ, 1);
    chk("bp drain1 in_ready", a_ird, 1);
    step();
    chk("bp drain2 head", a_odst, 6);
    chk("bp drain2 alu", a_oalu, 32'hC);
    a_iv = 1'b0;
    step();
    chk("bp drain3 valid", a_ov, 0);

    // Flush while FULL with D offered
    a_ord = 1'b0;
    a_put(1'b1, 4'd1, 32'h11, 1'b1, 1'b1);
    step();
    a_put(1'b1, 4'd2, 32'h22, 1'b1, 1'b1);
    step();
    chk("fl full occ", a_occ, 2);
    a_put(1'b1, 4'hD, 32'hDD, 1'b1, 1'b1);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_iv = 1'b0;
    chk("fl out_valid", a_ov, 0);
    chk("fl occ", a_occ, 0);
    chk("fl fwd_valid", a_fv, 0);
    chk("fl mre gated", a_omre, 0);
    chk("fl wbe gated", a_owbe, 0);
    chk("fl in_ready", a_ird, 1);
    step();
    chk("fl D absent", a_ov, 0);
    // Flush with one held entry, in_ready=1, D offered
    a_put(1'b1, 4'd4, 32'h44, 1'b0, 1'b1);
    step();
    chk("fl1 occ", a_occ, 1);
    a_put(1'b1, 4'hD, 32'hDD, 1'b0, 1'b1);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_iv = 1'b0;
    chk("fl1 occ after", a_occ, 0);
    chk("fl1 out_valid", a_ov, 0);
    step();
    chk("fl1 D absent", a_ov, 0);

    // Forwarding tap held during stall
    a_put(1'b1, 4'd7, 32'h77, 1'b1, 1'b1);
    step();
    a_iv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fwd valid", a_fv, 1);
      chk("fwd dest", a_fd, 7);
      chk("fwd mre", a_omre, 1);
      step();
    end
    a_ord = 1'b1;
    step();
    chk("fwd drained", a_fv, 0);
    a_ord = 1'b0;
    a_put(1'b1, 4'd2, 32'h99, 1'b0, 1'b0);
    step();
    a_iv = 1'b0;
    chk("nowb valid", a_ov, 1);
    chk("nowb fwd_valid", a_fv, 0);
    chk("nowb wbe", a_owbe, 0);
    chk("nowb fwd_dest", a_fd, 2);

    // SKID=0: combinational ready, single entry
    b_ord = 1'b0;
    b_iv = 1'b1; b_dst = 4'd1; b_alu = 32'h201; b_dat = 32'h301;
    b_mre = 1'b0; b_wbe = 1'b1;
    step();
    chk("s0 occ", b_occ, 1);
    chk("s0 head", b_odst, 1);
    #1;
    chk("s0 stall in_ready", b_ird, 0);
    step();
    chk("s0 stall head", b_odst, 1);
    chk("s0 stall occ", b_occ, 1);
    b_ord = 1'b1;
    #1;
    chk("s0 release in_ready", b_ird, 1);
    for (int i = 2; i <= 5; i++) begin
      b_dst = 4'(i);
      b_alu = 32'h200 + 32'(i);
      step();
      chk("s0 pass dest", b_odst, 64'(i));
      chk("s0 pass alu", b_oalu, 64'(32'h200 + 32'(i)));
      chk("s0 pass occ", b_occ, 1);
    end
    b_iv = 1'b0;
    step();
    chk("s0 drain valid", b_ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
